// File: rtl/hash_bits_off_min_tracker.sv
// Running-minimum tracker for popcount-tree Hamming distances; strict improvements are queued for the reporter.
// Optional HASH_BITS_OFF_THRESH_EN adds report_thresh_i: improvements above the threshold update best but are not queued.
module hash_bits_off_min_tracker #(
  parameter int NONCE_W    = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               bits_off_valid_i,
  input  logic [10:0]        bits_off_i,
  input  logic [NONCE_W-1:0] nonce_i,
`ifdef HASH_BITS_OFF_THRESH_EN
  input  logic [10:0]        report_thresh_i,
`endif
  output logic               report_valid_o,
  input  logic               report_ready_i,
  output logic [10:0]        report_bits_off_o,
  output logic [NONCE_W-1:0] report_nonce_o,
  output logic [10:0]        best_bits_off_o,
  output logic [15:0]        drop_count_o,
  output logic               range_err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [10:0]        best_q, best_d;
  logic [15:0]        drop_q, drop_d;
  logic               rerr_q, rerr_d;
  logic [10:0]        mem_bits_q  [FIFO_DEPTH];
  logic [NONCE_W-1:0] mem_nonce_q [FIFO_DEPTH];

  logic               we;
  logic [AW-1:0]      waddr;
  logic               empty, full, in_range, improve, push_req, pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_range = (bits_off_i <= 11'd1024);
  assign improve  = bits_off_valid_i && in_range && (bits_off_i < best_q);
`ifdef HASH_BITS_OFF_THRESH_EN
  assign push_req = improve && (bits_off_i <= report_thresh_i);
`else
  assign push_req = improve;
`endif
  assign pop      = !empty && report_ready_i;

  // A full queue with no pop this edge merges the new result into the newest entry.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    best_d   = best_q;
    drop_d   = drop_q;
    rerr_d   = rerr_q;
    we       = 1'b0;
    waddr    = wr_ptr_q[AW-1:0];
    if (bits_off_valid_i && !in_range) begin
      rerr_d = 1'b1;
    end
    if (improve) begin
      best_d = bits_off_i;
    end
    if (push_req) begin
      we = 1'b1;
      if (full && !pop) begin
        waddr = wr_ptr_q[AW-1:0] - AW'(1);
        if (drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end
      end else begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      best_q   <= 11'h7FF;
      drop_q   <= 16'd0;
      rerr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      best_q   <= best_d;
      drop_q   <= drop_d;
      rerr_q   <= rerr_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge clk_i) begin
    if (we && !rst_i) begin
      mem_bits_q[waddr]  <= bits_off_i;
      mem_nonce_q[waddr] <= nonce_i;
    end
  end

  assign report_valid_o    = !empty;
  assign report_bits_off_o = empty ? 11'd0 : mem_bits_q[rd_ptr_q[AW-1:0]];
  assign report_nonce_o    = empty ? '0    : mem_nonce_q[rd_ptr_q[AW-1:0]];
  assign best_bits_off_o   = best_q;
  assign drop_count_o      = drop_q;
  assign range_err_o       = rerr_q;

endmodule

// File: tb/tb_hash_bits_off_min_tracker.sv
// Self-checking bench for hash_bits_off_min_tracker: vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model. Honours HASH_BITS_OFF_THRESH_EN when defined.
module tb_hash_bits_off_min_tracker;

  localparam int NONCE_W = 64;
  localparam int DEPTH   = 4;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b0;
  logic               bits_off_valid_i = 1'b0;
  logic [10:0]        bits_off_i = '0;
  logic [NONCE_W-1:0] nonce_i = '0;
  logic [10:0]        thresh = 11'h7FF;
  logic               report_valid_o;
  logic               report_ready_i = 1'b0;
  logic [10:0]        report_bits_off_o;
  logic [NONCE_W-1:0] report_nonce_o;
  logic [10:0]        best_bits_off_o;
  logic [15:0]        drop_count_o;
  logic               range_err_o;

  int checks = 0;
  int fails  = 0;

  hash_bits_off_min_tracker #(.NONCE_W(NONCE_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .bits_off_valid_i  (bits_off_valid_i),
    .bits_off_i        (bits_off_i),
    .nonce_i           (nonce_i),
`ifdef HASH_BITS_OFF_THRESH_EN
    .report_thresh_i   (thresh),
`endif
    .report_valid_o    (report_valid_o),
    .report_ready_i    (report_ready_i),
    .report_bits_off_o (report_bits_off_o),
    .report_nonce_o    (report_nonce_o),
    .best_bits_off_o   (best_bits_off_o),
    .drop_count_o      (drop_count_o),
    .range_err_o       (range_err_o)
  );

  always #5 clk_i = ~clk_i;

  // reference model: the improvement queue as a plain SV queue
  typedef struct {
    logic [10:0]        bits;
    logic [NONCE_W-1:0] nonce;
  } ent_t;

  ent_t        mq[$];
  logic [10:0] m_best  = 11'h7FF;
  logic [15:0] m_drops = 16'd0;
  logic        m_rerr  = 1'b0;
  logic        m_rst_seen = 1'b0;
  int          cnt_kept = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic modelStep();
    bit   popm;
    ent_t e;
    if (rst_i) begin
      mq.delete();
      m_best = 11'h7FF;
      m_drops = 16'd0;
      m_rerr = 1'b0;
      m_rst_seen = 1'b1;
      return;
    end
    m_rst_seen = 1'b0;
    popm = (mq.size() > 0) && report_ready_i;
    if (bits_off_valid_i && bits_off_i > 11'd1024) begin
      m_rerr = 1'b1;
    end else if (bits_off_valid_i && bits_off_i < m_best) begin
      m_best = bits_off_i;
      e.bits = bits_off_i;
      e.nonce = nonce_i;
      if (bits_off_i <= thresh) begin
        if (mq.size() == DEPTH && !popm) begin
          mq[mq.size()-1] = e;
          if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
        end else begin
          mq.push_back(e);
        end
      end
    end
    if (popm) void'(mq.pop_front());
  endtask

  // drive inputs, take one edge, advance the model, settle away from the edge
  task automatic applyStimulus(input logic rst, input logic vld, input logic [10:0] bits,
                               input logic [NONCE_W-1:0] nonce, input logic rdy);
    rst_i = rst;
    bits_off_valid_i = vld;
    bits_off_i = bits;
    nonce_i = nonce;
    report_ready_i = rdy;
    @(posedge clk_i);
    modelStep();
    #1;
  endtask

  task automatic checkOutput();
    cmp("report_valid", 64'(report_valid_o), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      cmp("report_bits", 64'(report_bits_off_o), 64'(mq[0].bits));
      cmp("report_nonce", report_nonce_o, mq[0].nonce);
    end else if (m_rst_seen) begin
      cmp("report_bits_reset", 64'(report_bits_off_o), 64'd0);
      cmp("report_nonce_reset", report_nonce_o, 64'd0);
    end
    cmp("best", 64'(best_bits_off_o), 64'(m_best));
    cmp("drops", 64'(drop_count_o), 64'(m_drops));
    cmp("range_err", 64'(range_err_o), 64'(m_rerr));
  endtask

  function automatic logic [NONCE_W-1:0] nonceFor(input logic [10:0] b);
    return 64'hA5A5_0000_0000_0000 | 64'(b);
  endfunction

  typedef struct {
    logic        rst;
    logic        vld;
    logic [10:0] bits;
    logic        rdy;
    logic        exp_valid;
    logic [10:0] exp_bits;
    logic [10:0] exp_best;
    logic [15:0] exp_drops;
    logic        exp_rerr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [10:0] exp2 [4];
    logic [10:0] b;
    logic        v, r, rs;

    // basic improvements with ties, then out-of-range handling
    vecs[0] = '{1'b1, 1'b0, 11'd0,    1'b1, 1'b0, 11'd0,   11'h7FF, 16'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 11'd500,  1'b1, 1'b1, 11'd500, 11'd500, 16'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 11'd400,  1'b1, 1'b1, 11'd400, 11'd400, 16'd0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 11'd400,  1'b1, 1'b0, 11'd0,   11'd400, 16'd0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 11'd450,  1'b1, 1'b0, 11'd0,   11'd400, 16'd0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 11'd100,  1'b1, 1'b0, 11'd0,   11'd400, 16'd0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 11'd1025, 1'b1, 1'b0, 11'd0,   11'd400, 16'd0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 11'd2047, 1'b1, 1'b0, 11'd0,   11'd400, 16'd0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 11'd0,    1'b1, 1'b1, 11'd0,   11'd0,   16'd0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 11'd0,    1'b1, 1'b0, 11'd0,   11'd0,   16'd0, 1'b1};

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].bits, nonceFor(vecs[i].bits), vecs[i].rdy);
      checkOutput();
      cmp($sformatf("vec%0d_valid", i), 64'(report_valid_o), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        cmp($sformatf("vec%0d_bits", i), 64'(report_bits_off_o), 64'(vecs[i].exp_bits));
      cmp($sformatf("vec%0d_best", i), 64'(best_bits_off_o), 64'(vecs[i].exp_best));
      cmp($sformatf("vec%0d_drops", i), 64'(drop_count_o), 64'(vecs[i].exp_drops));
      cmp($sformatf("vec%0d_rerr", i), 64'(range_err_o), 64'(vecs[i].exp_rerr));
    end

    // overflow merges into newest entry, then in-order drain
    applyStimulus(1'b1, 1'b0, 11'd0, 64'd0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      b = 11'(900 - 100 * k);
      applyStimulus(1'b0, 1'b1, b, nonceFor(b), 1'b0);
      checkOutput();
    end
    cmp("ovf_drops", 64'(drop_count_o), 64'd2);
    cmp("ovf_best", 64'(best_bits_off_o), 64'd400);
    exp2[0] = 11'd900; exp2[1] = 11'd800; exp2[2] = 11'd700; exp2[3] = 11'd400;
    for (int k = 0; k < 4; k++) begin
      cmp($sformatf("drain%0d_valid", k), 64'(report_valid_o), 64'd1);
      cmp($sformatf("drain%0d_bits", k), 64'(report_bits_off_o), 64'(exp2[k]));
      applyStimulus(1'b0, 1'b0, 11'd0, 64'd0, 1'b1);
      checkOutput();
    end
    cmp("drain_empty", 64'(report_valid_o), 64'd0);

    // full queue with simultaneous pop and improvement: no drop, occupancy stays at depth
    applyStimulus(1'b1, 1'b0, 11'd0, 64'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      b = 11'(900 - 100 * k);
      applyStimulus(1'b0, 1'b1, b, nonceFor(b), 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 11'd300, nonceFor(11'd300), 1'b1);
    checkOutput();
    cmp("fullpop_drops", 64'(drop_count_o), 64'd0);
    cmp("fullpop_head", 64'(report_bits_off_o), 64'd800);
    cnt_kept = 0;
    for (int k = 0; k < 8; k++) begin
      if (report_valid_o) cnt_kept++;
      applyStimulus(1'b0, 1'b0, 11'd0, 64'd0, 1'b1);
      checkOutput();
    end
    cmp("fullpop_occupancy", 64'(cnt_kept), 64'd4);

    // reset mid-drain discards queued entries
    applyStimulus(1'b1, 1'b0, 11'd0, 64'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      b = 11'(600 - 50 * k);
      applyStimulus(1'b0, 1'b1, b, nonceFor(b), 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 11'd0, 64'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 11'd0, 64'd0, 1'b0);
    checkOutput();
    cmp("rst_valid", 64'(report_valid_o), 64'd0);
    cmp("rst_best", 64'(best_bits_off_o), 64'h7FF);

`ifdef HASH_BITS_OFF_THRESH_EN
    // threshold suppresses queuing but not the best update
    thresh = 11'd300;
    applyStimulus(1'b0, 1'b1, 11'd500, nonceFor(11'd500), 1'b0);
    applyStimulus(1'b0, 1'b1, 11'd350, nonceFor(11'd350), 1'b0);
    cmp("thr_none_yet", 64'(report_valid_o), 64'd0);
    cmp("thr_best_350", 64'(best_bits_off_o), 64'd350);
    applyStimulus(1'b0, 1'b1, 11'd290, nonceFor(11'd290), 1'b0);
    checkOutput();
    cmp("thr_head", 64'(report_bits_off_o), 64'd290);
    cmp("thr_best", 64'(best_bits_off_o), 64'd290);
    cmp("thr_drops", 64'(drop_count_o), 64'd0);
    applyStimulus(1'b0, 1'b0, 11'd0, 64'd0, 1'b1);
    cmp("thr_only_one", 64'(report_valid_o), 64'd0);
    thresh = 11'h7FF;
    applyStimulus(1'b1, 1'b0, 11'd0, 64'd0, 1'b0);
`endif

    // randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      rs = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0:       b = 11'($urandom_range(1025, 2047));
        1, 2:    b = 11'($urandom_range(0, 1024));
        3:       b = m_best;
        default: b = 11'($urandom_range(0, (m_best > 11'd1024) ? 1024 : int'(m_best)));
      endcase
`ifdef HASH_BITS_OFF_THRESH_EN
      if (rs) thresh = 11'($urandom_range(0, 1100));
`endif
      applyStimulus(rs, v, b, {$urandom, $urandom}, r);
      checkOutput();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
